// File: rtl/axi_rr_arbiter.sv
// N-to-1 AXI3 arbiter: independent round-robin read/write paths, one transaction in flight each, 1-cycle grant latency.
// Handshakes are combinational pass-throughs for the granted slot only; no skid buffering, so master stalls reach the requester directly.
module axi_rr_arbiter #(
    parameter int N      = 3,
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int A_W    = ID_W + ADDR_W + 24
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [N-1:0]                       s_arvalid,
    input  logic [N*A_W-1:0]                   s_ar,
    output logic [N-1:0]                       s_arready,
    output logic [N-1:0]                       s_rvalid,
    input  logic [N-1:0]                       s_rready,
    output logic [ID_W+DATA_W+3-1:0]           s_r,
    input  logic [N-1:0]                       s_awvalid,
    input  logic [N*A_W-1:0]                   s_aw,
    output logic [N-1:0]                       s_awready,
    input  logic [N-1:0]                       s_wvalid,
    input  logic [N*(DATA_W+DATA_W/8+1)-1:0]   s_w,
    output logic [N-1:0]                       s_wready,
    output logic [N-1:0]                       s_bvalid,
    input  logic [N-1:0]                       s_bready,
    output logic [ID_W+2-1:0]                  s_b,
    output logic                               m_arvalid,
    input  logic                               m_arready,
    output logic [A_W-1:0]                     m_ar,
    input  logic                               m_rvalid,
    output logic                               m_rready,
    input  logic [ID_W+DATA_W+3-1:0]           m_r,
    output logic                               m_awvalid,
    input  logic                               m_awready,
    output logic [A_W-1:0]                     m_aw,
    output logic                               m_wvalid,
    input  logic                               m_wready,
    output logic [DATA_W+DATA_W/8+1-1:0]       m_w,
    output logic [ID_W-1:0]                    m_wid,
    input  logic                               m_bvalid,
    output logic                               m_bready,
    input  logic [ID_W+2-1:0]                  m_b,
    output logic                               rd_busy,
    output logic                               wr_busy
);
    localparam int W_W = DATA_W + DATA_W/8 + 1;
    localparam int GW  = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_e;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_e;

    rd_state_e         rd_state_q, rd_state_d;
    wr_state_e         wr_state_q, wr_state_d;
    logic [GW-1:0]     rd_g_q, rd_g_d, rd_last_q, rd_last_d;
    logic [GW-1:0]     wr_g_q, wr_g_d, wr_last_q, wr_last_d;
    logic [ID_W-1:0]   wid_q, wid_d;

    // First requester after the last-granted one, wrapping modulo N.
    function automatic logic [GW-1:0] rr_pick(input logic [N-1:0] req, input logic [GW-1:0] last);
        logic [GW-1:0] pick;
        logic          found;
        int            idx;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= N; i++) begin
            idx = (int'(last) + i) % N;
            if (!found && req[idx]) begin
                pick  = idx[GW-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // ---------------- read path ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_state_q <= R_IDLE;
            rd_g_q     <= '0;
            rd_last_q  <= GW'(N-1);
        end else begin
            rd_state_q <= rd_state_d;
            rd_g_q     <= rd_g_d;
            rd_last_q  <= rd_last_d;
        end
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rd_g_d     = rd_g_q;
        rd_last_d  = rd_last_q;
        case (rd_state_q)
            R_IDLE: if (|s_arvalid) begin
                rd_g_d     = rr_pick(s_arvalid, rd_last_q);
                rd_state_d = R_ADDR;
            end
            R_ADDR: if (m_arvalid && m_arready) rd_state_d = R_DATA;
            R_DATA: if (m_rvalid && m_rready && m_r[0]) begin
                rd_last_d  = rd_g_q;
                rd_state_d = R_IDLE;
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        m_arvalid = 1'b0;
        m_ar      = '0;
        s_arready = '0;
        s_rvalid  = '0;
        m_rready  = 1'b0;
        case (rd_state_q)
            R_ADDR: begin
                m_arvalid         = s_arvalid[rd_g_q];
                m_ar              = s_ar[rd_g_q*A_W +: A_W];
                s_arready[rd_g_q] = m_arready;
            end
            R_DATA: begin
                s_rvalid[rd_g_q] = m_rvalid;
                m_rready         = s_rready[rd_g_q];
            end
            default: ;
        endcase
    end

    assign s_r     = m_r;
    assign rd_busy = (rd_state_q != R_IDLE);

    // ---------------- write path ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_state_q <= W_IDLE;
            wr_g_q     <= '0;
            wr_last_q  <= GW'(N-1);
            wid_q      <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            wr_g_q     <= wr_g_d;
            wr_last_q  <= wr_last_d;
            wid_q      <= wid_d;
        end
    end

    always_comb begin
        wr_state_d = wr_state_q;
        wr_g_d     = wr_g_q;
        wr_last_d  = wr_last_q;
        wid_d      = wid_q;
        case (wr_state_q)
            W_IDLE: if (|s_awvalid) begin
                wr_g_d     = rr_pick(s_awvalid, wr_last_q);
                wr_state_d = W_ADDR;
            end
            W_ADDR: begin
                // AW id sits in the top bits of the address payload
                wid_d = s_aw[wr_g_q*A_W + (A_W-ID_W) +: ID_W];
                if (m_awvalid && m_awready) wr_state_d = W_DATA;
            end
            W_DATA: if (m_wvalid && m_wready && m_w[0]) wr_state_d = W_RESP;
            W_RESP: if (m_bvalid && m_bready) begin
                wr_last_d  = wr_g_q;
                wr_state_d = W_IDLE;
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        m_awvalid = 1'b0;
        m_aw      = '0;
        s_awready = '0;
        m_wvalid  = 1'b0;
        m_w       = '0;
        s_wready  = '0;
        s_bvalid  = '0;
        m_bready  = 1'b0;
        case (wr_state_q)
            W_ADDR: begin
                m_awvalid         = s_awvalid[wr_g_q];
                m_aw              = s_aw[wr_g_q*A_W +: A_W];
                s_awready[wr_g_q] = m_awready;
            end
            W_DATA: begin
                m_wvalid         = s_wvalid[wr_g_q];
                m_w              = s_w[wr_g_q*W_W +: W_W];
                s_wready[wr_g_q] = m_wready;
            end
            W_RESP: begin
                s_bvalid[wr_g_q] = m_bvalid;
                m_bready         = s_bready[wr_g_q];
            end
            default: ;
        endcase
    end

    assign s_b     = m_b;
    assign m_wid   = wid_q;
    assign wr_busy = (wr_state_q != W_IDLE);

endmodule

// File: tb/tb_axi_rr_arbiter.sv
// Directed bench for axi_rr_arbiter; stimulus queues expected beats, negedge monitors pop and compare.
module tb_axi_rr_arbiter;
    localparam int N = 3, ID_W = 4, ADDR_W = 32, DATA_W = 32;
    localparam int A_W = ID_W + ADDR_W + 24;
    localparam int R_W = ID_W + DATA_W + 3;
    localparam int W_W = DATA_W + DATA_W/8 + 1;
    localparam int B_W = ID_W + 2;

    logic clk = 1'b0, reset = 1'b1;
    logic [N-1:0] s_arvalid = '0, s_rready = '0, s_awvalid = '0, s_wvalid = '0, s_bready = '0;
    logic [N-1:0][A_W-1:0] s_ar_a = '0, s_aw_a = '0;
    logic [N-1:0][W_W-1:0] s_w_a = '0;
    logic [N-1:0] s_arready, s_rvalid, s_awready, s_wready, s_bvalid;
    logic [R_W-1:0] s_r, m_r = '0;
    logic [B_W-1:0] s_b, m_b = '0;
    logic m_arvalid, m_arready = 1'b0, m_rvalid = 1'b0, m_rready;
    logic m_awvalid, m_awready = 1'b0, m_wvalid, m_wready = 1'b0, m_bvalid = 1'b0, m_bready;
    logic [A_W-1:0] m_ar, m_aw;
    logic [W_W-1:0] m_w;
    logic [ID_W-1:0] m_wid;
    logic rd_busy, wr_busy;

    axi_rr_arbiter #(.N(N), .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .A_W(A_W)) dut (
        .clk(clk), .reset(reset),
        .s_arvalid(s_arvalid), .s_ar(s_ar_a), .s_arready(s_arready),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_r(s_r),
        .s_awvalid(s_awvalid), .s_aw(s_aw_a), .s_awready(s_awready),
        .s_wvalid(s_wvalid), .s_w(s_w_a), .s_wready(s_wready),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_b(s_b),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_ar(m_ar),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_r(m_r),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_aw(m_aw),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_w(m_w), .m_wid(m_wid),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_b(m_b),
        .rd_busy(rd_busy), .wr_busy(wr_busy)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, w_hs = 0;
    logic [N+A_W-1:0]  exp_ar[$], exp_aw[$];
    logic [N+R_W-1:0]  exp_r[$];
    logic [ID_W+W_W-1:0] exp_w[$];
    logic [N+B_W-1:0]  exp_b[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sig_of(input int sel);
        case (sel)
            0: return m_arvalid;
            1: return m_awvalid;
            2: return m_bready;
            default: return m_rready;
        endcase
    endfunction

    task automatic wait_hi(input string nm, input int sel);
        int n = 0;
        #1;
        while (!sig_of(sel) && n < 20) begin
            tick();
            n++;
        end
        if (!sig_of(sel)) chk({nm, "_timeout"}, 1, 0);
    endtask

    function automatic logic [A_W-1:0] mk_a(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [7:0] len);
        logic [A_W-1:0] p;
        p = '0;
        p[A_W-1 -: ID_W] = id;
        p[A_W-ID_W-1 -: ADDR_W] = addr;
        p[A_W-ID_W-ADDR_W-1 -: 8] = len;
        p[13:0] = {3'd2, 2'b01, 2'b00, 4'b0011, 3'b000};
        return p;
    endfunction

    function automatic logic [N-1:0] oh(input int slot);
        logic [N-1:0] v;
        v = '0;
        v[slot] = 1'b1;
        return v;
    endfunction

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (!reset) begin
            if (m_arvalid && m_arready) begin
                if (exp_ar.size() == 0) chk("ar_unexpected", 1, 0);
                else chk("ar_grant_payload", {s_arready, m_ar}, exp_ar.pop_front());
            end
            if (m_rvalid && m_rready) begin
                if (exp_r.size() == 0) chk("r_unexpected", 1, 0);
                else chk("r_route_data", {s_rvalid, s_r}, exp_r.pop_front());
            end
            if (m_awvalid && m_awready) begin
                if (exp_aw.size() == 0) chk("aw_unexpected", 1, 0);
                else chk("aw_grant_payload", {s_awready, m_aw}, exp_aw.pop_front());
            end
            if (m_wvalid && m_wready) begin
                w_hs++;
                if (exp_w.size() == 0) chk("w_unexpected", 1, 0);
                else chk("w_wid_data", {m_wid, m_w}, exp_w.pop_front());
            end
            if (m_bvalid && m_bready) begin
                if (exp_b.size() == 0) chk("b_unexpected", 1, 0);
                else chk("b_route_resp", {s_bvalid, s_b}, exp_b.pop_front());
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic ar_phase(input int slot, input logic [A_W-1:0] pl);
        s_ar_a[slot] = pl;
        s_arvalid[slot] = 1'b1;
        exp_ar.push_back({oh(slot), pl});
        tick();
        wait_hi("arvalid", 0);
        m_arready = 1'b1;
        tick();
        m_arready = 1'b0;
        s_arvalid[slot] = 1'b0;
    endtask

    task automatic r_beat(input int slot, input logic [ID_W-1:0] id, input logic [31:0] data, input logic last);
        s_rready[slot] = 1'b1;
        m_rvalid = 1'b1;
        m_r = {id, data, 2'b00, last};
        exp_r.push_back({oh(slot), id, data, 2'b00, last});
        wait_hi("rready", 3);
        tick();
        m_rvalid = 1'b0;
        s_rready[slot] = 1'b0;
    endtask

    task automatic do_read(input int slot, input logic [ID_W-1:0] id, input logic [31:0] addr, input int nb, input logic [31:0] mult);
        ar_phase(slot, mk_a(id, addr, 8'(nb-1)));
        chk("rd_busy_in_data", rd_busy, 1);
        for (int b = 0; b < nb; b++) r_beat(slot, id, mult * (b+1), (b == nb-1));
        chk("rd_busy_after_rlast", rd_busy, 0);
    endtask

    task automatic do_write(input int slot, input logic [ID_W-1:0] id, input logic [31:0] addr, input int nb,
                            input logic [31:0] base, input logic [3:0] strb, input logic toggle);
        logic [A_W-1:0] pl;
        logic [W_W-1:0] wv;
        logic hs;
        int c = 0, n;
        pl = mk_a(id, addr, 8'(nb-1));
        s_aw_a[slot] = pl;
        s_awvalid[slot] = 1'b1;
        exp_aw.push_back({oh(slot), pl});
        tick();
        wait_hi("awvalid", 1);
        m_awready = 1'b1;
        tick();
        m_awready = 1'b0;
        s_awvalid[slot] = 1'b0;
        for (int b = 0; b < nb; b++) begin
            wv = {base + 32'(b), strb, (b == nb-1)};
            s_w_a[slot] = wv;
            s_wvalid[slot] = 1'b1;
            exp_w.push_back({id, wv});
            n = 0;
            do begin
                m_wready = toggle ? (c % 2 == 0) : 1'b1;
                #1;
                hs = m_wvalid && m_wready;
                tick();
                c++;
                n++;
            end while (!hs && n < 20);
            if (!hs) chk("w_timeout", 1, 0);
        end
        m_wready = 1'b1;
        s_bready[slot] = 1'b1;
        #1;
        chk("w_resp_no_wready", s_wready, 0);
        chk("w_resp_bready", m_bready, 1);
        s_wvalid[slot] = 1'b0;
        m_wready = 1'b0;
        m_bvalid = 1'b1;
        m_b = {id, 2'b00};
        exp_b.push_back({oh(slot), id, 2'b00});
        wait_hi("bready", 2);
        tick();
        m_bvalid = 1'b0;
        s_bready[slot] = 1'b0;
        chk("wr_busy_after_b", wr_busy, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int w0;
        // Reset state with requests pending: nothing may leak out
        s_arvalid = '1;
        s_awvalid = '1;
        tick();
        tick();
        chk("rst_rd_busy", rd_busy, 0);
        chk("rst_wr_busy", wr_busy, 0);
        chk("rst_readys", {s_arready, s_awready, s_wready}, 0);
        chk("rst_valids", {s_rvalid, s_bvalid}, 0);
        chk("rst_master", {m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready}, 0);
        chk("rst_wid", m_wid, 0);
        s_arvalid = '0;
        s_awvalid = '0;
        reset = 1'b0;
        tick();

        // Single DCache read, 4 beats 0x11..0x44
        do_read(1, 4'h1, 32'h1000, 4, 32'h11);

        // Stray R and B while idle
        m_rvalid = 1'b1;
        m_r = {4'h7, 32'hDEAD, 2'b00, 1'b1};
        m_bvalid = 1'b1;
        s_rready = '1;
        s_bready = '1;
        #1;
        chk("stray_rready", m_rready, 0);
        chk("stray_rvalid", s_rvalid, 0);
        chk("stray_bready", m_bready, 0);
        chk("stray_bvalid", s_bvalid, 0);
        tick();
        m_rvalid = 1'b0;
        m_bvalid = 1'b0;
        s_rready = '0;
        s_bready = '0;

        // Round robin with all three requesting continuously
        do_reset();
        for (int i = 0; i < N; i++) s_ar_a[i] = mk_a(4'(i+4), 32'h3000 + 32'(i*16), 8'd0);
        s_arvalid = '1;
        for (int k = 0; k < 6; k++) begin
            exp_ar.push_back({oh(k % N), s_ar_a[k % N]});
            tick();
            wait_hi("rr_arvalid", 0);
            m_arready = 1'b1;
            tick();
            m_arready = 1'b0;
            r_beat(k % N, 4'((k % N) + 4), 32'h100 + 32'(k), 1'b1);
        end
        s_arvalid = '0;

        // DCache 4-beat write under toggling wready
        w0 = w_hs;
        do_write(1, 4'h5, 32'h4000, 4, 32'hD0, 4'b1111, 1'b1);
        chk("w_handshake_count", w_hs - w0, 4);

        // Concurrent read (req 1) and write (req 2)
        fork
            do_read(1, 4'h1, 32'h5000, 4, 32'h10);
            do_write(2, 4'h2, 32'h6000, 1, 32'hE0, 4'b0011, 1'b0);
        join

        // Reset in R_DATA after 2 of 4 beats
        ar_phase(1, mk_a(4'h3, 32'h2000, 8'd3));
        r_beat(1, 4'h3, 32'hA1, 1'b0);
        r_beat(1, 4'h3, 32'hA2, 1'b0);
        reset = 1'b1;
        tick();
        chk("midrst_rd_busy", rd_busy, 0);
        chk("midrst_rvalid", s_rvalid, 0);
        reset = 1'b0;
        s_ar_a[0] = mk_a(4'h8, 32'h7000, 8'd0);
        s_ar_a[2] = mk_a(4'h9, 32'h8000, 8'd0);
        s_arvalid = 3'b101;
        exp_ar.push_back({oh(0), s_ar_a[0]});
        tick();
        wait_hi("post_rst_arvalid0", 0);
        m_arready = 1'b1;
        tick();
        m_arready = 1'b0;
        s_arvalid[0] = 1'b0;
        r_beat(0, 4'h8, 32'hB0, 1'b1);
        exp_ar.push_back({oh(2), s_ar_a[2]});
        tick();
        wait_hi("post_rst_arvalid2", 0);
        m_arready = 1'b1;
        tick();
        m_arready = 1'b0;
        s_arvalid[2] = 1'b0;
        r_beat(2, 4'h9, 32'hB2, 1'b1);

        tick();
        chk("drain_ar", exp_ar.size(), 0);
        chk("drain_r", exp_r.size(), 0);
        chk("drain_aw", exp_aw.size(), 0);
        chk("drain_w", exp_w.size(), 0);
        chk("drain_b", exp_b.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
